nbit_piso_tx: RTL

- Parallel-in/serial-out transmitter. It is the outbound counterpart of the team's n-bit parallel capture register.
- Accepts an N-bit word over a valid/ready handshake and drains it one bit per accepted serial beat.
- Sits between a datapath register stage and a bit-serial link or consumer.
- Supports consumer backpressure and emits a one-cycle completion pulse per word.

---
 rtl/nbit_piso_pkg.sv | 12 +
 rtl/nbit_piso_if.sv | 25 ++
 rtl/nbit_down_counter.sv | 30 +++
 rtl/nbit_piso_tx.sv | 90 +++++++++
 4 files changed

// File: rtl/nbit_piso_pkg.sv
// Shared constants and helpers for the n-bit parallel-in/serial-out transmitter.
package nbit_piso_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Bits needed to hold a bit count running from n down to 0.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/nbit_piso_if.sv
// Word-in / bit-out handshake bundle: master drives the word and serial ready, slave is the transmitter.
interface nbit_piso_if #(
  parameter int N = 32
);

  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_ready;
  logic         busy;
  logic         done;

  modport master (
    output in_data, in_valid, ser_ready,
    input  in_ready, ser_out, ser_valid, busy, done
  );

  modport slave (
    input  in_data, in_valid, ser_ready,
    output in_ready, ser_out, ser_valid, busy, done
  );

endinterface

// File: rtl/nbit_down_counter.sv
// Loadable down counter with a count==1 flag; updates one cycle after load/dec.
// Saturates at zero, so a stray dec can never wrap it back to full scale.
module nbit_down_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         is_one
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign count  = r_count;
  assign is_one = (r_count == W'(1));

endmodule

// File: rtl/nbit_piso_tx.sv
// Parallel-in/serial-out transmitter: first bit one cycle after capture, done one cycle after last bit.
// A low ser_ready freezes the current bit; ser_valid is never withdrawn mid-word.
module nbit_piso_tx
  import nbit_piso_pkg::*;
#(
  parameter int N         = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  nbit_piso_if.slave  bus
);

  localparam int CW = cnt_width(N);

  logic [0:0]    r_state;
  logic [N-1:0]  r_shreg;
  logic          r_in_ready;
  logic          r_done;

  logic          w_capture;
  logic          w_beat;
  logic          w_last;
  logic [0:0]    w_next_state;
  logic [CW-1:0] w_count;
  logic          w_cnt_is_one;
  logic          w_ser_bit;

  assign w_capture = (r_state == ST_IDLE) && bus.in_valid && r_in_ready;
  assign w_beat    = (r_state == ST_SHIFT) && bus.ser_ready;
  assign w_last    = w_beat && w_cnt_is_one;

  always_comb begin
    w_next_state = r_state;
    if (w_capture) begin
      w_next_state = ST_SHIFT;
    end else if (w_last) begin
      w_next_state = ST_IDLE;
    end
  end

  // in_ready is registered so it stays low through reset and the first cycle after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state == ST_IDLE);
      r_done     <= w_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
    end else if (w_capture) begin
      r_shreg <= bus.in_data;
    end else if (w_beat) begin
      if (MSB_FIRST) begin
        r_shreg <= {r_shreg[N-2:0], 1'b0};
      end else begin
        r_shreg <= {1'b0, r_shreg[N-1:1]};
      end
    end
  end

  nbit_down_counter #(
    .W (CW)
  ) u_bit_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_capture),
    .load_val (CW'(N)),
    .dec      (w_beat),
    .count    (w_count),
    .is_one   (w_cnt_is_one)
  );

  assign w_ser_bit = MSB_FIRST ? r_shreg[N-1] : r_shreg[0];

  assign bus.in_ready  = r_in_ready;
  assign bus.ser_valid = (r_state == ST_SHIFT);
  assign bus.ser_out   = (r_state == ST_SHIFT) && w_ser_bit;
  // The counter is non-zero exactly while a word is in flight.
  assign bus.busy      = (w_count != '0);
  assign bus.done      = r_done;

endmodule
